// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR sequencer and its step counter.
// Combinational definitions only; no latency or flow control of its own.
package lfsr_pkg;
    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hC8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;
endpackage

// File: rtl/lfsr_step_cnt.sv
// Step down-counter with a registered last flag; zero latency, load wins over decrement.
// The flag mirrors count==1, so RUN can leave on the cycle of its final step without a compare in the FSM.
module lfsr_step_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else if (load_i) begin
            cnt_q  <= load_val_i;
            last_q <= (load_val_i == CNT_W'(1));
        end else if (dec_i && cnt_q != '0) begin
            cnt_q  <= cnt_q - CNT_W'(1);
            last_q <= (cnt_q == CNT_W'(2));
        end
    end

    assign last_o = last_q;
endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Runs one seed/step job on an owned LFSR; response is valid N+2 cycles after acceptance.
// One job in flight: req_ready_o low outside IDLE, result held in DONE until rsp_ready_i.
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [LFSR_W-1:0] req_seed_i,
    input  logic [CNT_W-1:0]  req_steps_i,
    input  logic              abort_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [LFSR_W-1:0] rsp_data_o,
    output logic              rsp_zero_o,
    output logic              busy_o,
    output logic              lfsr_load_o,
    output logic [LFSR_W-1:0] lfsr_val_o,
    output logic              lfsr_step_o,
    input  logic [LFSR_W-1:0] lfsr_result_i
);
    state_e            state_q;
    logic              ready_q, load_q, step_q, valid_q, busy_q;
    logic [LFSR_W-1:0] seed_q;
    logic              zero_q, steps_nz_q;
    logic              accept;
    logic              last;

    assign accept = (state_q == IDLE) && ready_q && req_valid_i;

    lfsr_step_cnt #(.CNT_W(CNT_W)) u_step_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (accept),
        .load_val_i (req_steps_i),
        .dec_i      (step_q),
        .last_o     (last)
    );

    // Strobes are registered alongside the state so each one is a pure function of the current state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            load_q     <= 1'b0;
            step_q     <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            seed_q     <= '0;
            zero_q     <= 1'b0;
            steps_nz_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        seed_q     <= req_seed_i;
                        zero_q     <= (req_seed_i == '0);
                        steps_nz_q <= (req_steps_i != '0);
                        state_q    <= LOAD;
                        ready_q    <= 1'b0;
                        load_q     <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                LOAD: begin
                    load_q <= 1'b0;
                    if (abort_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else if (steps_nz_q) begin
                        state_q <= RUN;
                        step_q  <= 1'b1;
                    end else begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        state_q <= IDLE;
                        step_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else if (last) begin
                        state_q <= DONE;
                        step_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (abort_i || rsp_ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = valid_q;
    assign rsp_data_o  = valid_q ? lfsr_result_i : '0;
    assign rsp_zero_o  = valid_q & zero_q;
    assign busy_o      = busy_q;
    assign lfsr_load_o = load_q;
    assign lfsr_val_o  = seed_q;
    assign lfsr_step_o = step_q;
endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: behavioural LFSR on the lfsr_* ports, reference result from a plain step loop.
module tb_lfsr_seq_ctrl;
    import lfsr_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic [7:0] req_seed_i = 8'h00;
    logic [7:0] req_steps_i = 8'h00;
    logic       abort_i = 1'b0;
    logic       rsp_valid_o;
    logic       rsp_ready_i = 1'b0;
    logic [7:0] rsp_data_o;
    logic       rsp_zero_o;
    logic       busy_o;
    logic       lfsr_load_o;
    logic [7:0] lfsr_val_o;
    logic       lfsr_step_o;
    logic [7:0] lfsr_q;

    int total = 0;
    int bad   = 0;

    lfsr_seq_ctrl #(.CNT_W(8)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_seed_i    (req_seed_i),
        .req_steps_i   (req_steps_i),
        .abort_i       (abort_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .rsp_zero_o    (rsp_zero_o),
        .busy_o        (busy_o),
        .lfsr_load_o   (lfsr_load_o),
        .lfsr_val_o    (lfsr_val_o),
        .lfsr_step_o   (lfsr_step_o),
        .lfsr_result_i (lfsr_q)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] lfsr_next(input logic [7:0] r);
        return ((r << 1) & 8'hFF) ^ (r[7] ? LFSR_TAPS : 8'h00);
    endfunction

    function automatic logic [7:0] ref_result(input logic [7:0] seed, input int n);
        logic [7:0] r = seed;
        for (int i = 0; i < n; i++) r = lfsr_next(r);
        return r;
    endfunction

    // Stand-in for the scrambler register the controller drives.
    always @(posedge clk_i) begin
        if (lfsr_load_o) lfsr_q <= lfsr_val_o;
        else if (lfsr_step_o) lfsr_q <= lfsr_next(lfsr_q);
    end

    // Issues one job and gathers what the DUT did; called at #1 after a rising edge.
    task automatic do_job(input logic [7:0] seed, input logic [7:0] steps, input int hold,
                          input logic abort_on_req,
                          output int lat, output int nstep, output int nload, output int novl,
                          output logic [7:0] data, output logic zero, output logic stable,
                          output logic rdy_after, output logic got);
        lat = 0; nstep = 0; nload = 0; novl = 0;
        data = 8'h00; zero = 1'b0; stable = 1'b0; rdy_after = 1'b0; got = 1'b0;
        for (int i = 0; i < 20 && req_ready_o !== 1'b1; i++) begin
            @(posedge clk_i); #1;
        end
        req_valid_i = 1'b1;
        req_seed_i  = seed;
        req_steps_i = steps;
        abort_i     = abort_on_req;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        abort_i     = 1'b0;
        req_seed_i  = 8'($urandom);
        req_steps_i = 8'($urandom);
        for (int c = 0; c <= 400; c++) begin
            if (c > 0) begin
                @(posedge clk_i); #1;
            end
            if (lfsr_step_o === 1'b1) nstep++;
            if (lfsr_load_o === 1'b1) nload++;
            if (lfsr_step_o === 1'b1 && lfsr_load_o === 1'b1) novl++;
            if (rsp_valid_o === 1'b1) begin
                lat = c;
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            data   = rsp_data_o;
            zero   = rsp_zero_o;
            stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk_i); #1;
                if (rsp_valid_o !== 1'b1 || rsp_data_o !== data || rsp_zero_o !== zero) stable = 1'b0;
            end
            rsp_ready_i = 1'b1;
            @(posedge clk_i); #1;
            rsp_ready_i = 1'b0;
            rdy_after = req_ready_o;
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        #1;
        total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready_o); end
        total++; if (rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid_o); end
        total++; if (rsp_data_o !== 8'h00) begin bad++; $display("FAIL reset_rsp_data got=%h want=00", rsp_data_o); end
        total++; if ({rsp_zero_o, busy_o, lfsr_load_o, lfsr_step_o} !== 4'b0) begin
            bad++; $display("FAIL reset_strobes got=%b want=0000", {rsp_zero_o, busy_o, lfsr_load_o, lfsr_step_o});
        end
        total++; if (lfsr_val_o !== 8'h00) begin bad++; $display("FAIL reset_lfsr_val got=%h want=00", lfsr_val_o); end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", req_ready_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%b want=0", busy_o); end
    endtask

    task automatic test_basic;
        int lat, ns, nl, nov; logic [7:0] d; logic z, st, ra, got;
        do_job(8'h01, 8'd8, 0, 1'b0, lat, ns, nl, nov, d, z, st, ra, got);
        total++; if (!got) begin bad++; $display("FAIL basic_timeout no rsp_valid"); end
        total++; if (lat != 9) begin bad++; $display("FAIL basic_latency got=%0d want=9 edges after accept", lat); end
        total++; if (ns != 8 || nl != 1 || nov != 0) begin
            bad++; $display("FAIL basic_strobes steps=%0d loads=%0d overlap=%0d want 8/1/0", ns, nl, nov);
        end
        total++; if (d !== 8'hC8 || z !== 1'b0) begin bad++; $display("FAIL basic_data got=%h/%b want=c8/0", d, z); end
        total++; if (ra !== 1'b1) begin bad++; $display("FAIL basic_ready_after got=%b want=1", ra); end
    endtask

    task automatic test_stall;
        int lat, ns, nl, nov; logic [7:0] d; logic z, st, ra, got;
        do_job(8'h01, 8'd10, 5, 1'b0, lat, ns, nl, nov, d, z, st, ra, got);
        total++; if (d !== 8'hB0 || !got) begin bad++; $display("FAIL stall_data got=%h want=b0", d); end
        total++; if (st !== 1'b1) begin bad++; $display("FAIL stall_stable got=%b want=1", st); end
        total++; if (ra !== 1'b1) begin bad++; $display("FAIL stall_ready_after got=%b want=1", ra); end
    endtask

    task automatic test_zero_steps;
        int lat, ns, nl, nov; logic [7:0] d; logic z, st, ra, got;
        do_job(8'hA5, 8'd0, 0, 1'b0, lat, ns, nl, nov, d, z, st, ra, got);
        total++; if (ns != 0) begin bad++; $display("FAIL zsteps_pulses got=%0d want=0", ns); end
        total++; if (lat != 1 || !got) begin bad++; $display("FAIL zsteps_latency got=%0d want=1", lat); end
        total++; if (d !== 8'hA5) begin bad++; $display("FAIL zsteps_data got=%h want=a5", d); end
    endtask

    task automatic test_zero_seed;
        int lat, ns, nl, nov; logic [7:0] d; logic z, st, ra, got;
        do_job(8'h00, 8'd5, 1, 1'b0, lat, ns, nl, nov, d, z, st, ra, got);
        total++; if (d !== 8'h00 || z !== 1'b1 || !got) begin
            bad++; $display("FAIL zseed_result got=%h/%b want=00/1", d, z);
        end
    endtask

    task automatic test_max_steps;
        int lat, ns, nl, nov; logic [7:0] d, seed; logic z, st, ra, got;
        seed = 8'($urandom_range(1, 255));
        do_job(seed, 8'd255, 0, 1'b0, lat, ns, nl, nov, d, z, st, ra, got);
        total++; if (ns != 255 || lat != 256) begin
            bad++; $display("FAIL max_count steps=%0d lat=%0d want 255/256", ns, lat);
        end
        total++; if (d !== ref_result(seed, 255)) begin
            bad++; $display("FAIL max_data got=%h want=%h", d, ref_result(seed, 255));
        end
    endtask

    task automatic test_abort;
        int lat, ns, nl, nov, seen; logic [7:0] d; logic z, st, ra, got;
        req_valid_i = 1'b1; req_seed_i = 8'h01; req_steps_i = 8'd200;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        for (int i = 0; i < 10 && lfsr_step_o !== 1'b1; i++) begin
            @(posedge clk_i); #1;
        end
        repeat (2) begin @(posedge clk_i); #1; end
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        total++; if (lfsr_step_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL abort_run_drop step=%b busy=%b want 0/0", lfsr_step_o, busy_o);
        end
        total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL abort_run_ready got=%b want=1", req_ready_o); end
        seen = 0;
        repeat (10) begin
            @(posedge clk_i); #1;
            if (rsp_valid_o === 1'b1 || lfsr_step_o === 1'b1) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL abort_no_rsp got=%0d cycles want=0", seen); end
        // abort held with the request in IDLE must not block acceptance
        do_job(8'h01, 8'd8, 0, 1'b1, lat, ns, nl, nov, d, z, st, ra, got);
        total++; if (d !== 8'hC8 || !got) begin bad++; $display("FAIL abort_followup got=%h want=c8", d); end
        req_valid_i = 1'b1; req_seed_i = 8'h03; req_steps_i = 8'd2;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        for (int i = 0; i < 10 && rsp_valid_o !== 1'b1; i++) begin
            @(posedge clk_i); #1;
        end
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        total++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            bad++; $display("FAIL abort_done valid=%b ready=%b want 0/1", rsp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_reset_mid;
        req_valid_i = 1'b1; req_seed_i = 8'h01; req_steps_i = 8'd200;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        total++; if ({req_ready_o, rsp_valid_o, busy_o, lfsr_load_o, lfsr_step_o} !== 5'b0) begin
            bad++; $display("FAIL midreset_strobes got=%b want=00000",
                            {req_ready_o, rsp_valid_o, busy_o, lfsr_load_o, lfsr_step_o});
        end
        total++; if (lfsr_val_o !== 8'h00 || rsp_data_o !== 8'h00) begin
            bad++; $display("FAIL midreset_data val=%h rsp=%h want 00/00", lfsr_val_o, rsp_data_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b want=1", req_ready_o); end
    endtask

    task automatic test_back_to_back;
        int lat, ns, nl, nov, n; logic [7:0] d, seed; logic z, st, ra, got;
        for (int j = 0; j < 100; j++) begin
            seed = 8'($urandom);
            n    = $urandom_range(0, 30);
            do_job(seed, 8'(n), $urandom_range(0, 2), 1'($urandom), lat, ns, nl, nov, d, z, st, ra, got);
            total++;
            if (!got || d !== ref_result(seed, n) || z !== (seed == 8'h00) || lat != n + 1 || ns != n || ra !== 1'b1) begin
                bad++;
                $display("FAIL b2b job=%0d seed=%h n=%0d got=%h/%b lat=%0d steps=%0d rdy=%b want=%h/%b lat=%0d",
                         j, seed, n, d, z, lat, ns, ra, ref_result(seed, n), (seed == 8'h00), n + 1);
            end
        end
    endtask

    initial begin
        #2;
        test_reset;
        test_basic;
        test_stall;
        test_zero_steps;
        test_zero_seed;
        test_max_steps;
        test_abort;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lfsr_seq_ctrl.md
Name: lfsr_seq_ctrl

Overview:
Sequencer for the team's 8-bit shift-register scrambler (LFSR with synchronous seed load `rst_i`/`val` and step enable `start_i`). It accepts a job (seed, step count) over a valid/ready handshake, then loads the LFSR and clocks it exactly N steps. It returns the final LFSR value over a valid/ready response channel. It sits between a host/requester and one LFSR instance, which it owns exclusively.

Parameters:
- CNT_W, 8, width of the step-count field; maximum steps per job is 2^CNT_W-1.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  job request valid
- req_ready_o  out  1  controller can accept a job (high only in IDLE)
- req_seed_i  in  8  seed to load into the LFSR
- req_steps_i  in  CNT_W  number of LFSR steps to run
- abort_i  in  1  cancel the current job
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  result consumed
- rsp_data_o  out  8  final LFSR value
- rsp_zero_o  out  1  seed was 0x00 (the LFSR is stuck at zero); qualified by rsp_valid_o
- busy_o  out  1  high in LOAD, RUN or DONE
- lfsr_load_o  out  1  drives the LFSR's synchronous load/reset input
- lfsr_val_o  out  8  drives the LFSR seed input
- lfsr_step_o  out  1  drives the LFSR start/step input
- lfsr_result_i  in  8  LFSR register value

Behaviour:
- Async reset:
  - state=IDLE, step counter=0, seed/zero latches=0.
  - All outputs 0, except req_ready_o=1 after reset deasserts.
- State IDLE:
  - req_ready_o=1.
  - On req_valid_i&req_ready_o: latch seed and steps, latch zero flag (seed==0), go to LOAD.
- State LOAD (exactly 1 cycle):
  - lfsr_load_o=1, lfsr_val_o=latched seed, lfsr_step_o=0.
  - Next state is RUN if steps!=0, else DONE.
- State RUN:
  - lfsr_step_o=1 every cycle; counter decrements each cycle.
  - Exactly `steps` cycles with step asserted, then go to DONE.
  - lfsr_load_o is never high together with lfsr_step_o.
- State DONE:
  - rsp_valid_o=1.
  - rsp_data_o = lfsr_result_i (the LFSR is idle, so the value is stable).
  - rsp_data_o and rsp_zero_o hold until rsp_valid_o&rsp_ready_i, then go to IDLE.
- Latency:
  - Acceptance edge T. LOAD occupies the cycle after T.
  - rsp_valid_o first asserts on cycle T+2+N (N=steps).
  - N=0 gives rsp_data_o = seed.
- Back-to-back: req_ready_o re-asserts the cycle after the response handshake. There is no overlap; one job is in flight at a time.
- Abort:
  - abort_i in LOAD or RUN: go to IDLE next cycle, drop step/load immediately (combinational on state only, so effective from the next cycle); no response is issued.
  - abort_i in DONE: also discards the result.
  - abort_i in IDLE: ignored; a simultaneous req_valid_i is still accepted.
- LFSR model for checking, one step:
  - next = ((r<<1)&0xFF) ^ (r[7] ? 0xC8 : 0x00).
  - 0x00 stays 0x00.
- Reset mid-job: returns to IDLE asynchronously with all strobes low. LFSR content is undefined until the next LOAD.
- Held inputs: req_seed_i/req_steps_i changes after acceptance have no effect (latched).
- Maximum steps: steps=2^CNT_W-1 runs the full count with no wrap. The counter is CNT_W bits and counts down to 0.

Decomposition:
- Shared package lfsr_pkg:
  - state enum {IDLE, LOAD, RUN, DONE} (2-bit encoding);
  - LFSR_W=8;
  - LFSR_TAPS=8'hC8 (used by the bench reference model).
- One natural sub-module: lfsr_step_cnt. It is a CNT_W down-counter with load, decrement enable and a registered last flag (count==1 while decrementing), used to end RUN.
- For verification the bench instantiates the team's 8-bit LFSR connected to the lfsr_* ports.

Test Plan:
- Reset, then seed=0x01, steps=8 → 1 LOAD cycle, 8 step cycles; rsp_valid_o at T+10; rsp_data_o=0xC8, rsp_zero_o=0.
- Seed=0x01, steps=10, rsp_ready_i held low 5 cycles → rsp_data_o=0xB0 stable and rsp_valid_o high throughout; accepted on rsp_ready_i; req_ready_o=1 next cycle.
- Seed=0xA5, steps=0 → no lfsr_step_o pulses; rsp_data_o=0xA5 at T+2.
- Seed=0x00, steps=5 → rsp_data_o=0x00, rsp_zero_o=1.
- Seed=0x01, steps=200, abort_i pulsed on the 3rd RUN cycle → lfsr_step_o low from the next cycle; no rsp_valid_o; req_ready_o=1; a following job (0x01, 8) returns 0xC8.
- rst_i asserted mid-RUN between clock edges → all outputs 0 immediately; after release req_ready_o=1; back-to-back jobs match the reference model for 100 random seeds/steps.
